// File: rtl/hero_pkg.sv
// Shared encodings and default arena geometry for the hero group controller.
package hero_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_ATTACK = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef struct packed {
        logic mv;
        logic atk;
        dir_t dir;
    } cmd_t;

    localparam int DEF_CW       = 12;
    localparam int DEF_SIDE     = 60;
    localparam int DEF_STEP_LEN = 60;
    localparam int DEF_ATK_W    = 20;
    localparam int DEF_ATK_H    = 40;
    localparam int DEF_ATK_LEN  = 10;
    localparam int DEF_X_MIN    = 62;
    localparam int DEF_X_MAX    = 962;
    localparam int DEF_Y_MIN    = 108;
    localparam int DEF_Y_MAX    = 708;

    // Button priority: up > left > right > down > center.
    function automatic cmd_t decode_cmd(input logic up, input logic left,
                                        input logic right, input logic down,
                                        input logic center);
        cmd_t c;
        c.mv  = 1'b1;
        c.atk = 1'b0;
        c.dir = UP;
        if (up)         c.dir = UP;
        else if (left)  c.dir = LEFT;
        else if (right) c.dir = RIGHT;
        else if (down)  c.dir = DOWN;
        else begin
            c.mv  = 1'b0;
            c.atk = center;
        end
        return c;
    endfunction

    function automatic dir_t mirror_dir(input dir_t d, input logic m);
        dir_t r;
        r = d;
        if (m && d == LEFT)  r = RIGHT;
        if (m && d == RIGHT) r = LEFT;
        return r;
    endfunction

endpackage

// File: rtl/hero_axis_step.sv
// One-pixel step candidate for a single hero plus the blocked decision
// (collision nibble or arena wall), evaluated in CW+1 bits so 0 never wraps.
module hero_axis_step
    import hero_pkg::*;
#(
    parameter int CW    = DEF_CW,
    parameter int SIDE  = DEF_SIDE,
    parameter int X_MIN = DEF_X_MIN,
    parameter int X_MAX = DEF_X_MAX,
    parameter int Y_MIN = DEF_Y_MIN,
    parameter int Y_MAX = DEF_Y_MAX
) (
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  dir_t          dir,
    input  logic [3:0]    coll,
    output logic [CW-1:0] x_nxt,
    output logic [CW-1:0] y_nxt,
    output logic          blocked
);

    // x-1 < X_MIN rewritten as x < X_MIN+1 so that x=0 also counts as blocked.
    localparam logic [CW:0] LO_X  = (CW+1)'(X_MIN + 1);
    localparam logic [CW:0] LO_Y  = (CW+1)'(Y_MIN + 1);
    localparam logic [CW:0] HI_X  = (CW+1)'(X_MAX);
    localparam logic [CW:0] HI_Y  = (CW+1)'(Y_MAX);
    localparam logic [CW:0] SIDE1 = (CW+1)'(SIDE + 1);

    logic [CW:0] xe, ye;
    assign xe = {1'b0, x};
    assign ye = {1'b0, y};

    always_comb begin
        x_nxt   = x;
        y_nxt   = y;
        blocked = 1'b0;
        case (dir)
            LEFT: begin
                blocked = coll[0] | (xe < LO_X);
                x_nxt   = x - CW'(1);
            end
            RIGHT: begin
                blocked = coll[1] | ((xe + SIDE1) > HI_X);
                x_nxt   = x + CW'(1);
            end
            DOWN: begin
                blocked = coll[2] | ((ye + SIDE1) > HI_Y);
                y_nxt   = y + CW'(1);
            end
            default: begin
                blocked = coll[3] | (ye < LO_Y);
                y_nxt   = y - CW'(1);
            end
        endcase
    end

endmodule

// File: rtl/hero_group_ctl.sv
// Shared IDLE/MOVE/ATTACK controller for a group of heroes moving in lockstep,
// with per-hero mirroring, wall/collision blocking and a registered attack box.
module hero_group_ctl
    import hero_pkg::*;
#(
    parameter int                   N_HERO   = 2,
    parameter int                   CW       = DEF_CW,
    parameter int                   SIDE     = DEF_SIDE,
    parameter int                   STEP_LEN = DEF_STEP_LEN,
    parameter int                   ATK_W    = DEF_ATK_W,
    parameter int                   ATK_H    = DEF_ATK_H,
    parameter int                   ATK_LEN  = DEF_ATK_LEN,
    parameter int                   X_MIN    = DEF_X_MIN,
    parameter int                   X_MAX    = DEF_X_MAX,
    parameter int                   Y_MIN    = DEF_Y_MIN,
    parameter int                   Y_MAX    = DEF_Y_MAX,
    parameter logic [N_HERO-1:0]    MIRROR   = 2'b10,
    parameter logic [N_HERO*CW-1:0] X_INIT   = {12'd422, 12'd542},
    parameter logic [N_HERO*CW-1:0] Y_INIT   = {12'd648, 12'd648}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up,
    input  logic                   left,
    input  logic                   right,
    input  logic                   down,
    input  logic                   center,
    input  logic [4*N_HERO-1:0]    collision,
    output logic [N_HERO*CW-1:0]   x_pos,
    output logic [N_HERO*CW-1:0]   y_pos,
    output logic [N_HERO*CW-1:0]   atk_x,
    output logic [N_HERO*CW-1:0]   atk_y,
    output logic                   atk_valid,
    output logic                   busy
);

    localparam int CNT_W = $clog2(((STEP_LEN > ATK_LEN) ? STEP_LEN : ATK_LEN) + 1);
    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(STEP_LEN - 1);
    localparam logic [CNT_W-1:0] ATK_LAST  = CNT_W'(ATK_LEN - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               load_dir;
    cmd_t               cmd;
    dir_t               facing [N_HERO];

    logic [N_HERO-1:0][CW-1:0] x_cur, y_cur, x_step, y_step;
    logic [N_HERO-1:0][CW-1:0] x_nxt, y_nxt, ax_nxt, ay_nxt, ax_r, ay_r;
    logic [N_HERO-1:0]         blocked;

    assign cmd       = decode_cmd(up, left, right, down, center);
    assign x_pos     = x_cur;
    assign y_pos     = y_cur;
    assign atk_x     = ax_r;
    assign atk_y     = ay_r;
    assign atk_valid = (state == ST_ATTACK);
    assign busy      = (state != ST_IDLE);

    for (genvar h = 0; h < N_HERO; h++) begin : g_hero
        hero_axis_step #(
            .CW(CW), .SIDE(SIDE),
            .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
        ) u_step (
            .x       (x_cur[h]),
            .y       (y_cur[h]),
            .dir     (facing[h]),
            .coll    (collision[4*h +: 4]),
            .x_nxt   (x_step[h]),
            .y_nxt   (y_step[h]),
            .blocked (blocked[h])
        );
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_dir  = 1'b0;
        case (state)
            ST_MOVE: begin
                if (cnt == MOVE_LAST) begin
                    // Final step cycle: chain straight into the next command.
                    cnt_nxt = '0;
                    if (cmd.mv) begin
                        load_dir = 1'b1;
                    end else if (cmd.atk) begin
                        state_nxt = ST_ATTACK;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_ATTACK: begin
                if (cnt == ATK_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt = '0;
                if (cmd.mv) begin
                    state_nxt = ST_MOVE;
                    load_dir  = 1'b1;
                end else if (cmd.atk) begin
                    state_nxt = ST_ATTACK;
                end
            end
        endcase
    end

    // Attack box is built from the post-step position, so an attack that
    // follows a move directly sees the final pixel of that move.
    always_comb begin
        x_nxt  = x_cur;
        y_nxt  = y_cur;
        ax_nxt = '0;
        ay_nxt = '0;
        for (int h = 0; h < N_HERO; h++) begin
            if (state == ST_MOVE && !blocked[h]) begin
                x_nxt[h] = x_step[h];
                y_nxt[h] = y_step[h];
            end
            case (facing[h])
                RIGHT: begin
                    ax_nxt[h] = x_nxt[h] + CW'(SIDE);
                    ay_nxt[h] = y_nxt[h] + CW'(ATK_W);
                end
                LEFT: begin
                    ax_nxt[h] = (x_nxt[h] >= CW'(ATK_H)) ? x_nxt[h] - CW'(ATK_H) : '0;
                    ay_nxt[h] = y_nxt[h] + CW'(ATK_W);
                end
                UP: begin
                    ax_nxt[h] = x_nxt[h] + CW'(ATK_W);
                    ay_nxt[h] = (y_nxt[h] >= CW'(ATK_H)) ? y_nxt[h] - CW'(ATK_H) : '0;
                end
                default: begin
                    ax_nxt[h] = x_nxt[h] + CW'(ATK_W);
                    ay_nxt[h] = y_nxt[h] + CW'(SIDE);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            x_cur <= X_INIT;
            y_cur <= Y_INIT;
            ax_r  <= '0;
            ay_r  <= '0;
            for (int h = 0; h < N_HERO; h++) facing[h] <= UP;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            x_cur <= x_nxt;
            y_cur <= y_nxt;
            if (state_nxt == ST_ATTACK) begin
                ax_r <= ax_nxt;
                ay_r <= ay_nxt;
            end else begin
                ax_r <= '0;
                ay_r <= '0;
            end
            for (int h = 0; h < N_HERO; h++) begin
                if (load_dir) facing[h] <= mirror_dir(cmd.dir, MIRROR[h]);
            end
        end
    end

endmodule

// File: tb/tb_hero_group_ctl.sv
// Bench for hero_group_ctl: directed vector table, hand sequences for walls,
// chaining, attack and reset abort, then random buttons against a pixel model.
module tb_hero_group_ctl;

    localparam int M_IDLE = 0, M_MOVE = 1, M_ATK = 2;
    localparam int D_UP = 0, D_DN = 1, D_L = 2, D_R = 3;
    localparam logic [4:0] B_UP = 5'b10000, B_L = 5'b01000, B_R = 5'b00100,
                           B_DN = 5'b00010, B_C = 5'b00001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up = 1'b0, left = 1'b0, right = 1'b0, down = 1'b0, center = 1'b0;
    logic [7:0]  collision = 8'h00;
    logic [23:0] x_pos, y_pos, atk_x, atk_y;
    logic        atk_valid, busy;

    int checks = 0;
    int failures = 0;

    hero_group_ctl dut (
        .clk(clk), .rst(rst),
        .up(up), .left(left), .right(right), .down(down), .center(center),
        .collision(collision),
        .x_pos(x_pos), .y_pos(y_pos), .atk_x(atk_x), .atk_y(atk_y),
        .atk_valid(atk_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic [4:0] b);
        {up, left, right, down, center} = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_btn(5'b0);
        collision = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse a button for one sampled edge, leaving us just after that edge.
    task automatic pulse(input logic [4:0] b);
        set_btn(b);
        @(posedge clk);
        @(negedge clk);
        set_btn(5'b0);
    endtask

    // ---------------- reference model (pixel walk with cycle budgets) ----------
    int m_mode, m_rem;
    int mx [2];
    int my [2];
    int mf [2];

    task automatic model_reset();
        m_mode = M_IDLE;
        m_rem  = 0;
        mx[0] = 542; mx[1] = 422;
        my[0] = 648; my[1] = 648;
        mf[0] = D_UP; mf[1] = D_UP;
    endtask

    task automatic model_decide(input logic [4:0] b);
        int d;
        d = -1;
        if (b[4])      d = D_UP;
        else if (b[3]) d = D_L;
        else if (b[2]) d = D_R;
        else if (b[1]) d = D_DN;
        if (d >= 0) begin
            m_mode = M_MOVE;
            m_rem  = 60;
            mf[0]  = d;
            mf[1]  = (d == D_L) ? D_R : (d == D_R) ? D_L : d;
        end else if (b[0]) begin
            m_mode = M_ATK;
            m_rem  = 10;
        end else begin
            m_mode = M_IDLE;
        end
    endtask

    task automatic model_step(input logic [4:0] b, input logic [7:0] c);
        if (m_mode == M_MOVE) begin
            for (int h = 0; h < 2; h++) begin
                case (mf[h])
                    D_L:     if (!c[4*h]   && mx[h] - 1 >= 62)   mx[h] = mx[h] - 1;
                    D_R:     if (!c[4*h+1] && mx[h] + 61 <= 962) mx[h] = mx[h] + 1;
                    D_DN:    if (!c[4*h+2] && my[h] + 61 <= 708) my[h] = my[h] + 1;
                    default: if (!c[4*h+3] && my[h] - 1 >= 108)  my[h] = my[h] - 1;
                endcase
            end
            m_rem--;
            if (m_rem == 0) model_decide(b);
        end else if (m_mode == M_ATK) begin
            m_rem--;
            if (m_rem == 0) m_mode = M_IDLE;
        end else begin
            model_decide(b);
        end
    endtask

    task automatic model_compare(input int cyc);
        int ax [2];
        int ay [2];
        for (int h = 0; h < 2; h++) begin
            ax[h] = 0;
            ay[h] = 0;
            if (m_mode == M_ATK) begin
                case (mf[h])
                    D_R:  begin ax[h] = mx[h] + 60; ay[h] = my[h] + 20; end
                    D_L:  begin ax[h] = (mx[h] >= 40) ? mx[h] - 40 : 0; ay[h] = my[h] + 20; end
                    D_UP: begin ax[h] = mx[h] + 20; ay[h] = (my[h] >= 40) ? my[h] - 40 : 0; end
                    default: begin ax[h] = mx[h] + 20; ay[h] = my[h] + 60; end
                endcase
            end
        end
        chk($sformatf("rnd%0d x_pos", cyc), x_pos, {12'(mx[1]), 12'(mx[0])});
        chk($sformatf("rnd%0d y_pos", cyc), y_pos, {12'(my[1]), 12'(my[0])});
        chk($sformatf("rnd%0d atk_x", cyc), atk_x, {12'(ax[1]), 12'(ax[0])});
        chk($sformatf("rnd%0d atk_y", cyc), atk_y, {12'(ay[1]), 12'(ay[0])});
        chk($sformatf("rnd%0d atk_valid", cyc), atk_valid, m_mode == M_ATK);
        chk($sformatf("rnd%0d busy", cyc), busy, m_mode != M_IDLE);
    endtask

    // ---------------- directed vector table -----------------------------------
    typedef struct {
        logic [4:0] btn;
        logic [7:0] coll;
        int         wait_n;
        int         x0, x1, y0, y1, ax0, ax1, ay0, ay1;
        logic       av, bsy;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int bubbles;
        logic [4:0] rb;
        logic [7:0] rc;

        vecs[0]  = '{B_R,  8'h00, 60, 602, 362, 648, 648,   0,   0,   0,   0, 1'b0, 1'b0};
        vecs[1]  = '{B_R,  8'h00, 30, 572, 392, 648, 648,   0,   0,   0,   0, 1'b0, 1'b1};
        vecs[2]  = '{B_L,  8'h01, 60, 542, 482, 648, 648,   0,   0,   0,   0, 1'b0, 1'b0};
        vecs[3]  = '{B_L,  8'h20, 60, 482, 422, 648, 648,   0,   0,   0,   0, 1'b0, 1'b0};
        vecs[4]  = '{B_UP, 8'h00, 60, 542, 422, 588, 588,   0,   0,   0,   0, 1'b0, 1'b0};
        vecs[5]  = '{B_UP, 8'h08, 60, 542, 422, 648, 588,   0,   0,   0,   0, 1'b0, 1'b0};
        vecs[6]  = '{B_DN, 8'h00, 60, 542, 422, 648, 648,   0,   0,   0,   0, 1'b0, 1'b0};
        vecs[7]  = '{B_C,  8'h00,  0, 542, 422, 648, 648, 562, 442, 608, 608, 1'b1, 1'b1};
        vecs[8]  = '{B_C,  8'h00,  9, 542, 422, 648, 648, 562, 442, 608, 608, 1'b1, 1'b1};
        vecs[9]  = '{B_C,  8'h00, 10, 542, 422, 648, 648,   0,   0,   0,   0, 1'b0, 1'b0};
        vecs[10] = '{5'b10001, 8'h00, 60, 542, 422, 588, 588, 0, 0, 0,   0, 1'b0, 1'b0};
        vecs[11] = '{5'b01100, 8'h00, 60, 482, 482, 648, 648, 0, 0, 0,   0, 1'b0, 1'b0};

        // Reset state, sampled while rst is held.
        @(negedge clk);
        chk("reset x_pos", x_pos, {12'd422, 12'd542});
        chk("reset y_pos", y_pos, {12'd648, 12'd648});
        chk("reset atk_x", atk_x, 24'd0);
        chk("reset atk_y", atk_y, 24'd0);
        chk("reset atk_valid", atk_valid, 1'b0);
        chk("reset busy", busy, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_reset();
            collision = vecs[i].coll;
            pulse(vecs[i].btn);
            repeat (vecs[i].wait_n) @(negedge clk);
            chk($sformatf("vec%0d x_pos", i), x_pos, {12'(vecs[i].x1), 12'(vecs[i].x0)});
            chk($sformatf("vec%0d y_pos", i), y_pos, {12'(vecs[i].y1), 12'(vecs[i].y0)});
            chk($sformatf("vec%0d atk_x", i), atk_x, {12'(vecs[i].ax1), 12'(vecs[i].ax0)});
            chk($sformatf("vec%0d atk_y", i), atk_y, {12'(vecs[i].ay1), 12'(vecs[i].ay0)});
            chk($sformatf("vec%0d atk_valid", i), atk_valid, vecs[i].av);
            chk($sformatf("vec%0d busy", i), busy, vecs[i].bsy);
        end

        // Right move then attack: both boxes for all ten cycles, then cleared.
        do_reset();
        pulse(B_R);
        repeat (60) @(negedge clk);
        chk("seq_atk pre busy", busy, 1'b0);
        pulse(B_C);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("seq_atk c%0d valid", k), atk_valid, 1'b1);
            chk($sformatf("seq_atk c%0d atk_x", k), atk_x, {12'd322, 12'd662});
            chk($sformatf("seq_atk c%0d atk_y", k), atk_y, {12'd668, 12'd668});
            chk($sformatf("seq_atk c%0d x_pos", k), x_pos, {12'd362, 12'd602});
            @(negedge clk);
        end
        chk("seq_atk end valid", atk_valid, 1'b0);
        chk("seq_atk end atk_x", atk_x, 24'd0);
        chk("seq_atk end atk_y", atk_y, 24'd0);
        chk("seq_atk end busy", busy, 1'b0);

        // Up held: back-to-back moves with no idle gap, stops at the top wall.
        do_reset();
        set_btn(B_UP);
        @(posedge clk);
        bubbles = 0;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            if (!busy) bubbles++;
        end
        chk("seq_up bubbles", bubbles, 0);
        chk("seq_up y_pos", y_pos, {12'd108, 12'd108});
        chk("seq_up x_pos", x_pos, {12'd422, 12'd542});
        set_btn(5'b0);
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        chk("seq_up idle", busy, 1'b0);

        // Right held: hero0 stops at the right wall, mirrored hero1 at the left.
        set_btn(B_R);
        repeat (400) @(negedge clk);
        set_btn(5'b0);
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        chk("seq_wall idle", busy, 1'b0);
        chk("seq_wall x_pos", x_pos, {12'd62, 12'd902});
        chk("seq_wall y_pos", y_pos, {12'd108, 12'd108});

        // Reset mid-move aborts immediately.
        do_reset();
        pulse(B_R);
        repeat (30) @(negedge clk);
        chk("seq_rst mid x_pos", x_pos, {12'd392, 12'd572});
        #2 rst = 1'b1;
        #1;
        chk("seq_rst x_pos", x_pos, {12'd422, 12'd542});
        chk("seq_rst y_pos", y_pos, {12'd648, 12'd648});
        chk("seq_rst busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("seq_rst after busy", busy, 1'b0);
        chk("seq_rst after x_pos", x_pos, {12'd422, 12'd542});

        // Random buttons, collisions and occasional resets against the model.
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            model_compare(i);
            for (int b = 0; b < 5; b++) rb[b] = ($urandom_range(0, 5) == 0);
            for (int b = 0; b < 8; b++) rc[b] = ($urandom_range(0, 7) == 0);
            set_btn(rb);
            collision = rc;
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            @(posedge clk);
            if (!rst) model_step(rb, rc);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
